// File: rtl/wave_raster_writer_if.sv
// rtl/wave_raster_writer_if.sv - sample stream and frame-buffer write port bundle
//
// Purpose: groups the amplitude sample handshake and the pixel write bus of
// wave_raster_writer so the writer and its environment connect through one port.
//
// Signals:
//   s_valid       sample valid (driven by the sample source)
//   s_ready       writer accepts a sample this cycle
//   s_amp         sample amplitude, 0 = bottom row
//   trace_colour  12-bit RGB colour for lit pixels of this sample
//   wr_en         frame-buffer write strobe
//   wr_addr       frame-buffer address, row-major (y*H_PIX + x)
//   wr_data       12-bit RGB pixel colour
//
// Modports:
//   master  the writer: consumes samples, drives the frame-buffer write bus
//   slave   the environment: sample source and frame-buffer sink
interface wave_raster_writer_if #(
    parameter int AMP_W = 7
);
    logic             s_valid;
    logic             s_ready;
    logic [AMP_W-1:0] s_amp;
    logic [11:0]      trace_colour;
    logic             wr_en;
    logic [15:0]      wr_addr;
    logic [11:0]      wr_data;

    modport master (
        input  s_valid, s_amp, trace_colour,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output s_valid, s_amp, trace_colour,
        input  s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/wave_raster_writer.sv
// rtl/wave_raster_writer.sv - renders one amplitude sample per column into a row-major frame buffer
//
// Purpose: for every display column, accepts one amplitude sample, then writes
// the whole vertical strip (V_PIX pixels, top row first) into the frame buffer
// that the scan-out block reads. Address = y*H_PIX + x, built incrementally.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin one frame; only honoured in IDLE
//   bus         wave_raster_writer_if.master (sample stream + buffer write bus)
//   busy        high whenever not IDLE
//   frame_done  one-cycle pulse after the last pixel write of a frame
//
// Optional feature macro: WAVE_LINE_FILL_EN
//   defined   - pixels between the previous and current column's rows are lit,
//               producing a connected trace (column 0 uses its own row only)
//   undefined - only the current column's row is lit (dot trace)
module wave_raster_writer #(
    parameter int          H_PIX     = 240,
    parameter int          V_PIX     = 120,
    parameter int          AMP_W     = 7,
    parameter logic [11:0] BG_COLOUR = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    wave_raster_writer_if.master bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int              XW       = $clog2(H_PIX);
    localparam int              YW       = $clog2(V_PIX);
    localparam logic [YW-1:0]   Y_LAST   = YW'(V_PIX - 1);
    localparam logic [XW-1:0]   X_LAST   = XW'(H_PIX - 1);
    localparam logic [15:0]     ROW_STEP = 16'(H_PIX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DRAW   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [XW-1:0] x;
    logic [YW-1:0] y;          // row currently presented on the write bus
    logic [YW-1:0] row_cur;
    logic [11:0]   colour;
    logic          wr_en_q;
    logic [15:0]   wr_addr_q;
    logic [11:0]   wr_data_q;

    logic          hs;
    logic [31:0]   amp_ext;
    logic [YW-1:0] row_new;
    logic [YW-1:0] row_src;
    logic [YW-1:0] y_nxt;
    logic [11:0]   colour_src;
    logic          lit;
    logic [11:0]   pix_nxt;

`ifdef WAVE_LINE_FILL_EN
    logic [YW-1:0] row_prev;
    logic [YW-1:0] prev_src;
    logic [YW-1:0] lo;
    logic [YW-1:0] hi;
`endif

    // Next-state and status outputs
    always_comb begin
        state_nxt   = state;
        hs          = 1'b0;
        bus.s_ready = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    hs        = 1'b1;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (y == Y_LAST) begin
                    state_nxt = (x == X_LAST) ? DONE : ACCEPT;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel for the row that will be on the bus next cycle. During the handshake
    // the new sample is not latched yet, so its values are taken straight from
    // the stream; that lets the first write follow the handshake immediately.
    always_comb begin
        amp_ext    = 32'(bus.s_amp);
        row_new    = (amp_ext > 32'(V_PIX - 1)) ? '0 : Y_LAST - YW'(amp_ext);
        row_src    = (state == ACCEPT) ? row_new : row_cur;
        colour_src = (state == ACCEPT) ? bus.trace_colour : colour;
        y_nxt      = (state == ACCEPT) ? '0 : y + 1'b1;
`ifdef WAVE_LINE_FILL_EN
        prev_src   = (x == '0) ? row_src : row_prev;
        lo         = (prev_src < row_src) ? prev_src : row_src;
        hi         = (prev_src < row_src) ? row_src : prev_src;
        lit        = (y_nxt >= lo) && (y_nxt <= hi);
`else
        lit        = (y_nxt == row_src);
`endif
        pix_nxt    = lit ? colour_src : BG_COLOUR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            row_cur   <= Y_LAST;
            colour    <= BG_COLOUR;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= BG_COLOUR;
`ifdef WAVE_LINE_FILL_EN
            row_prev  <= Y_LAST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x <= '0;
                    end
                end
                ACCEPT: begin
                    if (hs) begin
                        row_cur   <= row_new;
                        colour    <= bus.trace_colour;
                        y         <= '0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= 16'(x);
                        wr_data_q <= pix_nxt;
                    end
                end
                DRAW: begin
                    if (y == Y_LAST) begin
                        wr_en_q  <= 1'b0;
`ifdef WAVE_LINE_FILL_EN
                        row_prev <= row_cur;
`endif
                        if (x != X_LAST) begin
                            x <= x + 1'b1;
                        end
                    end else begin
                        y         <= y_nxt;
                        wr_addr_q <= wr_addr_q + ROW_STEP;
                        wr_data_q <= pix_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_wave_raster_writer.sv
// tb/tb_wave_raster_writer.sv - randomized self-checking bench for wave_raster_writer
module tb_wave_raster_writer;
    localparam int H    = 240;
    localparam int V    = 120;
    localparam int NPIX = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    wave_raster_writer_if #(.AMP_W(7)) bus ();

    wave_raster_writer #(
        .H_PIX(H), .V_PIX(V), .AMP_W(7), .BG_COLOUR(12'h000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int timeouts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed frame buffer
    logic [11:0] obs_data [NPIX];
    int          obs_cnt  [NPIX];
    int          wr_total, oor, fd_count, first_wr_cyc, last_wr_cyc, first_wr_addr;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (int'(bus.wr_addr) < NPIX) begin
                obs_cnt[bus.wr_addr]  = obs_cnt[bus.wr_addr] + 1;
                obs_data[bus.wr_addr] = bus.wr_data;
            end else begin
                oor++;
            end
            if (wr_total == 0) begin
                first_wr_cyc  = cyc;
                first_wr_addr = int'(bus.wr_addr);
            end
            last_wr_cyc = cyc;
            wr_total++;
        end
        if (frame_done) fd_count++;
    end

    // Reference model: samples of the current frame, one per column
    int          amps [$];
    logic [11:0] cols [$];

    function automatic int row_of(input int a);
        return V - 1 - ((a > V - 1) ? V - 1 : a);
    endfunction

    function automatic logic [11:0] exp_pix(input int xx, input int yy);
        int rc, rp, lo, hi;
        rc = row_of(amps[xx]);
        rp = (xx == 0) ? rc : row_of(amps[xx - 1]);
`ifdef WAVE_LINE_FILL_EN
        lo = (rc < rp) ? rc : rp;
        hi = (rc < rp) ? rp : rc;
`else
        lo = rc;
        hi = rc;
`endif
        return (yy >= lo && yy <= hi) ? cols[xx] : 12'h000;
    endfunction

    task automatic score_image(input int ncols, output int bad, output int first);
        bad   = 0;
        first = -1;
        for (int a = 0; a < NPIX; a++) begin
            int          xx, yy, ecnt;
            logic [11:0] e;
            xx   = a % H;
            yy   = a / H;
            ecnt = (xx < ncols) ? 1 : 0;
            e    = (xx < ncols) ? exp_pix(xx, yy) : 12'h000;
            if (obs_cnt[a] != ecnt || (ecnt == 1 && obs_data[a] !== e)) begin
                bad++;
                if (first < 0) first = a;
            end
        end
    endtask

    task automatic clear_obs();
        for (int a = 0; a < NPIX; a++) begin
            obs_cnt[a]  = 0;
            obs_data[a] = 12'h000;
        end
        wr_total = 0; oor = 0; fd_count = 0;
        first_wr_cyc = -1; last_wr_cyc = -1; first_wr_addr = -1;
        amps.delete();
        cols.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
    endtask

    // Called at a negedge; returns at the negedge of the cycle after start.
    task automatic start_frame(output int sc);
        start = 1'b1;
        sc    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first write cycle.
    task automatic send_sample(input int a, input logic [11:0] c, input int gap, output int hs);
        int n = 0;
        repeat (gap) @(negedge clk);
        amps.push_back(a);
        cols.push_back(c);
        bus.s_valid      = 1'b1;
        bus.s_amp        = 7'(a);
        bus.trace_colour = c;
        while (!bus.s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) timeouts++;
        @(negedge clk);
        hs          = cyc;
        bus.s_valid = 1'b0;
        bus.s_amp   = 7'($urandom);
    endtask

    task automatic wait_done(output int fdc);
        int n = 0;
        while (!frame_done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) timeouts++;
        fdc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
            bus.s_valid = ~bus.s_valid;
            bus.s_amp = 7'($urandom);
            #1;
            checks += 6;
            if (bus.wr_en !== 1'b0)        begin failures++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
            if (bus.s_ready !== 1'b0)      begin failures++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
            if (busy !== 1'b0)             begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
            if (frame_done !== 1'b0)       begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
            if (bus.wr_addr !== 16'd0)     begin failures++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
            if (bus.wr_data !== 12'h000)   begin failures++; $display("FAIL reset_wr_data: got %h want 000", bus.wr_data); end
        end
        start = 1'b0;
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0)        begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL idle_s_ready: got %b want 0", bus.s_ready); end
        if (wr_total != 0)        begin failures++; $display("FAIL idle_writes: got %0d want 0", wr_total); end
    endtask

    task automatic test_single_column();
        int sc, hs, bad, first;
        do_reset();
        start_frame(sc);
        checks++;
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL start_to_ready: got %b want 1", bus.s_ready); end
        send_sample(0, 12'hF00, 0, hs);
        repeat (125) @(negedge clk);
        score_image(1, bad, first);
        checks += 6;
        if (wr_total != V)            begin failures++; $display("FAIL single_count: got %0d want %0d", wr_total, V); end
        if (first_wr_cyc != hs)       begin failures++; $display("FAIL single_first_cyc: got %0d want %0d", first_wr_cyc, hs); end
        if (last_wr_cyc != hs + V - 1) begin failures++; $display("FAIL single_last_cyc: got %0d want %0d", last_wr_cyc, hs + V - 1); end
        if (obs_data[28560] !== 12'hF00) begin failures++; $display("FAIL single_lit: got %h want F00", obs_data[28560]); end
        if (bad != 0)                 begin failures++; $display("FAIL single_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        if (bus.s_ready !== 1'b1)     begin failures++; $display("FAIL single_ready_again: got %b want 1", bus.s_ready); end
    endtask

    task automatic test_clamp();
        int sc, hs, bad, first;
        logic [11:0] c;
        do_reset();
        start_frame(sc);
        for (int i = 0; i < 3; i++) send_sample($urandom_range(0, 127), 12'($urandom_range(1, 4095)), $urandom_range(0, 3), hs);
        c = 12'($urandom_range(1, 4095));
        send_sample(127, c, 0, hs);
        repeat (125) @(negedge clk);
        score_image(4, bad, first);
        checks += 4;
        if (obs_data[3] !== c) begin failures++; $display("FAIL clamp_top: got %h want %h", obs_data[3], c); end
        if (oor != 0)          begin failures++; $display("FAIL clamp_range: out_of_range=%0d want 0", oor); end
        if (bad != 0)          begin failures++; $display("FAIL clamp_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        if (timeouts != 0)     begin failures++; $display("FAIL clamp_timeout: got %0d want 0", timeouts); end
    endtask

    task automatic test_full_frame();
        int sc, hs, bad, first, fdc;
        do_reset();
        start_frame(sc);
        for (int i = 0; i < H; i++) send_sample(60, 12'($urandom_range(1, 4095)), $urandom_range(0, 3), hs);
        wait_done(fdc);
        checks += 2;
        if (busy !== 1'b1)          begin failures++; $display("FAIL full_busy_at_done: got %b want 1", busy); end
        if (fdc != last_wr_cyc + 1) begin failures++; $display("FAIL full_done_cyc: got %0d want %0d", fdc, last_wr_cyc + 1); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)       begin failures++; $display("FAIL full_busy_after: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL full_done_pulse: got %b want 0", frame_done); end
        repeat (3) @(negedge clk);
        score_image(H, bad, first);
        checks += 5;
        if (wr_total != NPIX) begin failures++; $display("FAIL full_count: got %0d want %0d", wr_total, NPIX); end
        if (fd_count != 1)    begin failures++; $display("FAIL full_done_count: got %0d want 1", fd_count); end
        if (bad != 0)         begin failures++; $display("FAIL full_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        if (oor != 0)         begin failures++; $display("FAIL full_range: out_of_range=%0d want 0", oor); end
        if (timeouts != 0)    begin failures++; $display("FAIL full_timeout: got %0d want 0", timeouts); end
    endtask

    task automatic test_back_to_back();
        int sc, hs, bad, first, fdc;
        do_reset();
        start_frame(sc);
        for (int i = 0; i < H; i++) send_sample($urandom_range(0, 127), 12'($urandom_range(1, 4095)), 0, hs);
        wait_done(fdc);
        repeat (3) @(negedge clk);
        score_image(H, bad, first);
        checks += 3;
        if (fdc - sc + 1 != 1 + H * (V + 1) + 1) begin failures++; $display("FAIL b2b_length: got %0d want %0d", fdc - sc + 1, 1 + H * (V + 1) + 1); end
        if (bad != 0)                            begin failures++; $display("FAIL b2b_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        if (busy !== 1'b0)                       begin failures++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_line_fill();
        int sc, hs, bad, first, lit0, lit1, want1;
        do_reset();
        start_frame(sc);
        send_sample(10, 12'h0F0, $urandom_range(0, 3), hs);
        send_sample(20, 12'h00F, $urandom_range(0, 3), hs);
        repeat (125) @(negedge clk);
        lit0 = 0;
        lit1 = 0;
        for (int yy = 0; yy < V; yy++) begin
            if (obs_data[yy * H] != 12'h000) lit0++;
            if (obs_data[yy * H + 1] != 12'h000) lit1++;
        end
`ifdef WAVE_LINE_FILL_EN
        want1 = 11;
`else
        want1 = 1;
`endif
        score_image(2, bad, first);
        checks += 4;
        if (lit0 != 1)                       begin failures++; $display("FAIL fill_col0_count: got %0d want 1", lit0); end
        if (obs_data[109 * H] !== 12'h0F0)   begin failures++; $display("FAIL fill_col0_row: got %h want 0F0", obs_data[109 * H]); end
        if (lit1 != want1)                   begin failures++; $display("FAIL fill_col1_count: got %0d want %0d", lit1, want1); end
        if (bad != 0)                        begin failures++; $display("FAIL fill_image: bad=%0d want 0 first_addr=%0d", bad, first); end
    endtask

    task automatic test_interference();
        int sc, hs, bad, first;
        do_reset();
        start_frame(sc);
        for (int i = 0; i < 5; i++) begin
            send_sample($urandom_range(0, 127), 12'($urandom_range(1, 4095)), $urandom_range(0, 2), hs);
            if (i == 1) begin
                start = 1'b1;
                repeat (10) @(negedge clk);
                start = 1'b0;
            end
        end
        repeat (125) @(negedge clk);
        score_image(5, bad, first);
        checks++;
        if (bad != 0) begin failures++; $display("FAIL intf_start_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        send_sample($urandom_range(0, 127), 12'($urandom_range(1, 4095)), 0, hs);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL intf_async_wr_en: got %b want 0", bus.wr_en); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL intf_async_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
        start_frame(sc);
        send_sample($urandom_range(0, 127), 12'($urandom_range(1, 4095)), 0, hs);
        repeat (125) @(negedge clk);
        score_image(1, bad, first);
        checks += 3;
        if (first_wr_addr != 0) begin failures++; $display("FAIL intf_restart_addr: got %0d want 0", first_wr_addr); end
        if (bad != 0)           begin failures++; $display("FAIL intf_restart_image: bad=%0d want 0 first_addr=%0d", bad, first); end
        if (timeouts != 0)      begin failures++; $display("FAIL intf_timeout: got %0d want 0", timeouts); end
    endtask

    initial begin
        bus.s_valid      = 1'b0;
        bus.s_amp        = '0;
        bus.trace_colour = 12'h000;
        clear_obs();
        test_reset();
        test_single_column();
        test_clamp();
        test_line_fill();
        test_interference();
        test_full_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_raster_writer.md
# wave_raster_writer

Writer side of the waveform frame buffer. Accepts one amplitude sample per display column, renders each column as a vertical strip of 12-bit RGB pixels, and writes the full 240x120 bitmap into the dual-port buffer that the VGA scan-out block reads. Buffer layout is row-major, x fastest: address = y*H_PIX + x. This matches the scan-out block's address sequence.

## Interface
Parameters:
- H_PIX, 240, columns per frame (samples per frame)
- V_PIX, 120, rows per frame
- AMP_W, 7, sample width
- BG_COLOUR, 12'h000, colour written to unlit pixels

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin rendering one frame; sampled only in IDLE
- s_valid  in  1  sample valid
- s_ready  out  1  block accepts sample this cycle
- s_amp  in  AMP_W  sample amplitude; 0 = bottom row
- trace_colour  in  12  colour for lit pixels ({R[3:0],G[3:0],B[3:0]}); sampled at each handshake
- wr_en  out  1  buffer write strobe
- wr_addr  out  16  buffer address
- wr_data  out  12  pixel colour
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last pixel of frame

## Operation
- States: IDLE, ACCEPT, DRAW, DONE.
- IDLE: start=1 -> ACCEPT. Column counter x cleared to 0. start is ignored in any other state.
- ACCEPT: s_ready=1. On s_valid&&s_ready:
  - latch the clamped amplitude: amp_c = min(s_amp, V_PIX-1)
  - compute row_cur = V_PIX-1-amp_c
  - latch trace_colour
  - -> DRAW
- DRAW: one write per cycle for y = 0..V_PIX-1.
  - wr_addr = y*H_PIX + x, generated incrementally (start at x, add H_PIX per row). No multiplier.
  - wr_data = trace colour if pixel lit, else BG_COLOUR.
  - After y = V_PIX-1: row_prev <= row_cur.
  - If x == H_PIX-1 -> DONE; else x <= x+1 and -> ACCEPT.
- DONE: frame_done=1 for one cycle -> IDLE.
- Pixel lit (macro absent): y == row_cur.
- s_ready is 0 outside ACCEPT. Samples presented then are held by the sender (valid/ready rule: s_amp stable while s_valid && !s_ready).
- Address width: the maximum address is H_PIX*V_PIX-1 = 28799, which fits in 16 bits. The address never wraps within a frame.

## Timing
- Reset values:
  - s_ready, wr_en, busy, frame_done = 0
  - wr_addr = 0, wr_data = BG_COLOUR
  - state = IDLE, x = 0, row_prev = V_PIX-1
- Reset acts immediately, mid-frame included; wr_en drops without waiting for a clock edge. The next start re-renders from address 0.
- start -> s_ready high on the next cycle.
- Handshake cycle N -> wr_en high on cycles N+1..N+V_PIX, contiguous, with wr_addr/wr_data registered. s_ready returns high on cycle N+V_PIX+1 for the next column.
- The last write of a frame is on cycle L. frame_done is high on L+1. busy is 0 from L+2.
- Frame length with a zero-wait sender: 1 + H_PIX*(V_PIX+1) + 1 cycles from start.

## Configuration
- WAVE_LINE_FILL_EN defined:
  - A pixel is lit when min(row_prev,row_cur) <= y <= max(row_prev,row_cur). This draws a connected trace.
  - For column 0, row_prev is forced to row_cur.
- Undefined: only y == row_cur is lit (dot trace), and the row_prev register is omitted.
- Cycle timing is identical in both builds.

## Test plan
- Reset: hold rst_n=0 and toggle start and s_valid. Expected: all outputs at reset values and no wr_en. Then release and confirm the block idles.
- Single column: start, then s_amp=0 with trace_colour=12'hF00. Expected: 120 writes to addresses 0, 240, ..., 28560. Only address 28560 receives 12'hF00; the rest receive 12'h000.
- Clamp: s_amp=127 in column 3. Expected: only address 3 is lit; no address exceeds 28799.
- Full frame: 240 samples of amp=60 with random s_valid gaps. Expected: exactly 28800 writes, every address 0..28799 written once. Row 59 is lit in every column. frame_done pulses once and busy falls one cycle later.
- Line fill (WAVE_LINE_FILL_EN): samples 10 then 20. Expected: column 1 lit at rows 99..109, 11 pixels. Without the macro, only row 99 is lit. Column 0 is lit only at row 109 in both builds.
- Interference: assert start during DRAW. Expected: no effect. Assert rst_n=0 mid-column 5. Expected: wr_en low at once; a new start writes column 0 starting at address 0.
